// File: rtl/cu_pkg.sv
// Shared definitions for the control unit.
// This package holds the FSM state encoding, the 5-bit opcodes, the IR field
// positions, and the bit index of each ALU select line.
package cu_pkg;

    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_HALT = 4'd8
    } state_t;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_SHR = 5'b00101;
    localparam logic [4:0] OP_SHL = 5'b00110;
    localparam logic [4:0] OP_ROR = 5'b00111;
    localparam logic [4:0] OP_ROL = 5'b01000;
    localparam logic [4:0] OP_AND = 5'b01001;
    localparam logic [4:0] OP_OR  = 5'b01010;
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;
    localparam logic [4:0] OP_NEG = 5'b10001;
    localparam logic [4:0] OP_NOT = 5'b10010;

    // IR field positions: opcode, then the Ra/Rb/Rc register numbers
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    // ALU select vector, ADD in the MSB down to NOT in the LSB
    localparam int ALU_W   = 12;
    localparam int ALU_ADD = 11;
    localparam int ALU_SUB = 10;
    localparam int ALU_MUL = 9;
    localparam int ALU_DIV = 8;
    localparam int ALU_SHR = 7;
    localparam int ALU_SHL = 6;
    localparam int ALU_ROR = 5;
    localparam int ALU_ROL = 4;
    localparam int ALU_AND = 3;
    localparam int ALU_OR  = 2;
    localparam int ALU_NEG = 1;
    localparam int ALU_NOT = 0;

    // Register number to one-hot strobe vector
    function automatic logic [15:0] reg_onehot(input logic [3:0] idx);
        logic [15:0] one;
        one = 16'h0001;
        return one << idx;
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational instruction decoder: IR -> one-hot ALU select, one-hot
// Ra/Rb/Rc strobes, and the illegal / multiply-divide / unary flags.
// Macro CU_MULDIV_EN: when undefined, MUL and DIV decode as illegal.
module cu_decode
    import cu_pkg::*;
(
    input  logic [31:0]      ir_i,
    output logic [ALU_W-1:0] alu_sel_o,
    output logic [15:0]      ra_oh_o,
    output logic [15:0]      rb_oh_o,
    output logic [15:0]      rc_oh_o,
    output logic             illegal_o,
    output logic             muldiv_o,
    output logic             unary_o
);

    logic [4:0] opcode;
    logic       unused_ir_bits;

    assign opcode         = ir_i[OP_MSB:OP_LSB];
    assign ra_oh_o        = reg_onehot(ir_i[RA_MSB:RA_LSB]);
    assign rb_oh_o        = reg_onehot(ir_i[RB_MSB:RB_LSB]);
    assign rc_oh_o        = reg_onehot(ir_i[RC_MSB:RC_LSB]);
    assign unused_ir_bits = ^ir_i[RC_LSB-1:0];

    // Opcode to ALU select; anything not listed is illegal and selects nothing
    always_comb begin
        alu_sel_o = '0;
        illegal_o = 1'b0;
        muldiv_o  = 1'b0;
        unary_o   = 1'b0;
        case (opcode)
            OP_ADD: alu_sel_o[ALU_ADD] = 1'b1;
            OP_SUB: alu_sel_o[ALU_SUB] = 1'b1;
            OP_SHR: alu_sel_o[ALU_SHR] = 1'b1;
            OP_SHL: alu_sel_o[ALU_SHL] = 1'b1;
            OP_ROR: alu_sel_o[ALU_ROR] = 1'b1;
            OP_ROL: alu_sel_o[ALU_ROL] = 1'b1;
            OP_AND: alu_sel_o[ALU_AND] = 1'b1;
            OP_OR:  alu_sel_o[ALU_OR]  = 1'b1;
`ifdef CU_MULDIV_EN
            OP_MUL: begin
                alu_sel_o[ALU_MUL] = 1'b1;
                muldiv_o           = 1'b1;
            end
            OP_DIV: begin
                alu_sel_o[ALU_DIV] = 1'b1;
                muldiv_o           = 1'b1;
            end
`endif
            OP_NEG: begin
                alu_sel_o[ALU_NEG] = 1'b1;
                unary_o            = 1'b1;
            end
            OP_NOT: begin
                alu_sel_o[ALU_NOT] = 1'b1;
                unary_o            = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired control unit: Moore sequencer T0..T6 that emits datapath
// strobes, decoded from the state register and the instruction register.
// Macro CU_MULDIV_EN enables MUL/DIV (two-step result write via LO/HI, T6).
module control_unit
    import cu_pkg::*;
(
    input  logic        Clock_i,
    input  logic        Reset_i,
    input  logic [31:0] IR_i,
    input  logic        MemStall_i,
    input  logic        Stop_i,
    output logic [15:0] Rin_o,
    output logic [15:0] Rout_o,
    output logic        PCout_o,
    output logic        PCin_o,
    output logic        IncPC_o,
    output logic        MARin_o,
    output logic        MDRin_o,
    output logic        MDRout_o,
    output logic        IRin_o,
    output logic        RYin_o,
    output logic        RZin_o,
    output logic        Zlowout_o,
    output logic        Zhighout_o,
    output logic        HIin_o,
    output logic        LOin_o,
    output logic        Read_o,
    output logic        ADD_o,
    output logic        SUB_o,
    output logic        MUL_o,
    output logic        DIV_o,
    output logic        SHR_o,
    output logic        SHL_o,
    output logic        ROR_o,
    output logic        ROL_o,
    output logic        AND_o,
    output logic        OR_o,
    output logic        NEGATE_o,
    output logic        NOT_o,
    output logic        Run_o,
    output logic        Illegal_o
);

    state_t           state_q;
    logic [ALU_W-1:0] alu_sel;
    logic [ALU_W-1:0] alu_act;
    logic [15:0]      ra_oh;
    logic [15:0]      rb_oh;
    logic [15:0]      rc_oh;
    logic             illegal;
    logic             muldiv;
    logic             unary;

    cu_decode u_decode (
        .ir_i      (IR_i),
        .alu_sel_o (alu_sel),
        .ra_oh_o   (ra_oh),
        .rb_oh_o   (rb_oh),
        .rc_oh_o   (rc_oh),
        .illegal_o (illegal),
        .muldiv_o  (muldiv),
        .unary_o   (unary)
    );

    // Sequencer: fetch T0-T2, operand T3, execute T4, write-back T5 (T6 for HI)
    always_ff @(posedge Clock_i or posedge Reset_i) begin
        if (Reset_i) begin
            state_q <= ST_RST;
        end else begin
            case (state_q)
                ST_RST:  state_q <= ST_T0;
                ST_T0:   state_q <= ST_T1;
                ST_T1:   if (!MemStall_i) state_q <= ST_T2;
                ST_T2:   state_q <= ST_T3;
                ST_T3:   state_q <= illegal ? ST_T0 : ST_T4;
                ST_T4:   state_q <= ST_T5;
                ST_T5: begin
                    if (muldiv)      state_q <= ST_T6;
                    else if (Stop_i) state_q <= ST_HALT;
                    else             state_q <= ST_T0;
                end
                ST_T6:   state_q <= Stop_i ? ST_HALT : ST_T0;
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_RST;
            endcase
        end
    end

    // Strobe decode; one bus driver per state, PCin only once the memory is ready
    always_comb begin
        Rin_o      = '0;
        Rout_o     = '0;
        PCout_o    = 1'b0;
        PCin_o     = 1'b0;
        IncPC_o    = 1'b0;
        MARin_o    = 1'b0;
        MDRin_o    = 1'b0;
        MDRout_o   = 1'b0;
        IRin_o     = 1'b0;
        RYin_o     = 1'b0;
        RZin_o     = 1'b0;
        Zlowout_o  = 1'b0;
        Zhighout_o = 1'b0;
        HIin_o     = 1'b0;
        LOin_o     = 1'b0;
        Read_o     = 1'b0;
        alu_act    = '0;
        Illegal_o  = 1'b0;
        Run_o      = (state_q != ST_RST) && (state_q != ST_HALT);
        case (state_q)
            ST_T0: begin
                PCout_o = 1'b1;
                MARin_o = 1'b1;
                IncPC_o = 1'b1;
                RZin_o  = 1'b1;
            end
            ST_T1: begin
                Zlowout_o = 1'b1;
                Read_o    = 1'b1;
                MDRin_o   = 1'b1;
                PCin_o    = !MemStall_i;
            end
            ST_T2: begin
                MDRout_o = 1'b1;
                IRin_o   = 1'b1;
            end
            ST_T3: begin
                Rout_o    = rb_oh;
                RYin_o    = 1'b1;
                Illegal_o = illegal;
            end
            ST_T4: begin
                Rout_o  = unary ? rb_oh : rc_oh;
                alu_act = alu_sel;
                RZin_o  = 1'b1;
            end
            ST_T5: begin
                Zlowout_o = 1'b1;
                if (muldiv) LOin_o = 1'b1;
                else        Rin_o  = ra_oh;
            end
            ST_T6: begin
                Zhighout_o = 1'b1;
                HIin_o     = 1'b1;
            end
            default: ;
        endcase
    end

    assign ADD_o    = alu_act[ALU_ADD];
    assign SUB_o    = alu_act[ALU_SUB];
    assign SHR_o    = alu_act[ALU_SHR];
    assign SHL_o    = alu_act[ALU_SHL];
    assign ROR_o    = alu_act[ALU_ROR];
    assign ROL_o    = alu_act[ALU_ROL];
    assign AND_o    = alu_act[ALU_AND];
    assign OR_o     = alu_act[ALU_OR];
    assign NEGATE_o = alu_act[ALU_NEG];
    assign NOT_o    = alu_act[ALU_NOT];

`ifdef CU_MULDIV_EN
    assign MUL_o = alu_act[ALU_MUL];
    assign DIV_o = alu_act[ALU_DIV];
`else
    logic unused_muldiv;
    assign unused_muldiv = alu_act[ALU_MUL] | alu_act[ALU_DIV];
    assign MUL_o = 1'b0;
    assign DIV_o = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the stimulus process pushes the expected
// output vector for each cycle, a monitor pops and compares it.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ir = 32'h0;
    logic        mem_stall = 1'b0;
    logic        stop = 1'b0;

    logic [15:0] rin, rout;
    logic pcout, pcin, incpc, marin, mdrin, mdrout, irin, ryin, rzin;
    logic zlowout, zhighout, hiin, loin, rd;
    logic add_s, sub_s, mul_s, div_s, shr_s, shl_s, ror_s, rol_s, and_s, or_s, neg_s, not_s;
    logic run, illegal;

    control_unit dut (
        .Clock_i(clk), .Reset_i(rst), .IR_i(ir), .MemStall_i(mem_stall), .Stop_i(stop),
        .Rin_o(rin), .Rout_o(rout), .PCout_o(pcout), .PCin_o(pcin), .IncPC_o(incpc),
        .MARin_o(marin), .MDRin_o(mdrin), .MDRout_o(mdrout), .IRin_o(irin),
        .RYin_o(ryin), .RZin_o(rzin), .Zlowout_o(zlowout), .Zhighout_o(zhighout),
        .HIin_o(hiin), .LOin_o(loin), .Read_o(rd),
        .ADD_o(add_s), .SUB_o(sub_s), .MUL_o(mul_s), .DIV_o(div_s), .SHR_o(shr_s),
        .SHL_o(shl_s), .ROR_o(ror_s), .ROL_o(rol_s), .AND_o(and_s), .OR_o(or_s),
        .NEGATE_o(neg_s), .NOT_o(not_s), .Run_o(run), .Illegal_o(illegal)
    );

    always #5 clk = ~clk;

    // strobe masks: PCout in the MSB down to Read in the LSB
    localparam logic [13:0] S_PCOUT = 14'h2000, S_PCIN  = 14'h1000, S_INCPC = 14'h0800;
    localparam logic [13:0] S_MARIN = 14'h0400, S_MDRIN = 14'h0200, S_MDROUT = 14'h0100;
    localparam logic [13:0] S_IRIN  = 14'h0080, S_RYIN  = 14'h0040, S_RZIN  = 14'h0020;
    localparam logic [13:0] S_ZLO   = 14'h0010, S_ZHI   = 14'h0008, S_HIIN  = 14'h0004;
    localparam logic [13:0] S_LOIN  = 14'h0002, S_READ  = 14'h0001;
    // ALU masks: ADD in the MSB down to NOT in the LSB
    localparam logic [11:0] A_ADD = 12'h800, A_SUB = 12'h400, A_MUL = 12'h200;
    localparam logic [11:0] A_AND = 12'h008, A_OR  = 12'h004, A_NEG = 12'h002;

    logic [59:0] act;
    assign act = {rin, rout, pcout, pcin, incpc, marin, mdrin, mdrout, irin, ryin, rzin,
                  zlowout, zhighout, hiin, loin, rd, add_s, sub_s, mul_s, div_s, shr_s,
                  shl_s, ror_s, rol_s, and_s, or_s, neg_s, not_s, run, illegal};

    int total = 0;
    int bad   = 0;
    logic [59:0] exp_q[$];
    string       name_q[$];

    function automatic logic [59:0] mk(input logic [15:0] rin_e, input logic [15:0] rout_e,
                                       input logic [13:0] s, input logic [11:0] a,
                                       input logic run_e, input logic ill_e);
        return {rin_e, rout_e, s, a, run_e, ill_e};
    endfunction

    function automatic logic [15:0] oh(input int n);
        logic [15:0] one;
        one = 16'h0001;
        return one << n;
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'd0};
    endfunction

    function automatic logic [59:0] e_off();
        return '0;
    endfunction
    function automatic logic [59:0] e_t0();
        return mk(16'h0, 16'h0, S_PCOUT | S_MARIN | S_INCPC | S_RZIN, 12'h0, 1'b1, 1'b0);
    endfunction
    function automatic logic [59:0] e_t1(input logic pcin_e);
        return mk(16'h0, 16'h0, S_ZLO | S_READ | S_MDRIN | (pcin_e ? S_PCIN : 14'h0), 12'h0, 1'b1, 1'b0);
    endfunction
    function automatic logic [59:0] e_t2();
        return mk(16'h0, 16'h0, S_MDROUT | S_IRIN, 12'h0, 1'b1, 1'b0);
    endfunction
    function automatic logic [59:0] e_t3(input int rb, input logic ill_e);
        return mk(16'h0, oh(rb), S_RYIN, 12'h0, 1'b1, ill_e);
    endfunction
    function automatic logic [59:0] e_t4(input int r, input logic [11:0] a);
        return mk(16'h0, oh(r), S_RZIN, a, 1'b1, 1'b0);
    endfunction
    function automatic logic [59:0] e_t5(input int ra);
        return mk(oh(ra), 16'h0, S_ZLO, 12'h0, 1'b1, 1'b0);
    endfunction
    function automatic logic [59:0] e_t5m();
        return mk(16'h0, 16'h0, S_ZLO | S_LOIN, 12'h0, 1'b1, 1'b0);
    endfunction
    function automatic logic [59:0] e_t6();
        return mk(16'h0, 16'h0, S_ZHI | S_HIIN, 12'h0, 1'b1, 1'b0);
    endfunction

    function automatic void check(input string nm, input logic [59:0] a, input logic [59:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, a, e);
        end else begin
            $display("chk %s ok val=%h", nm, a);
        end
    endfunction

    // monitor: compare one expectation per cycle, also right after an async reset
    always begin : monitor
        logic [59:0] e;
        string       nm;
        @(negedge clk or posedge rst);
        #1;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check(nm, act, e);
        end
    end

    // queue the expectation for the current cycle, then advance one clock
    task automatic cyc(input logic [59:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int stalls, input string tag);
        for (int i = 0; i < stalls; i++) begin
            mem_stall = 1'b1;
            cyc(e_t1(1'b0), {tag, "_t1_stall"});
        end
        mem_stall = 1'b0;
        cyc(e_t1(1'b1), {tag, "_t1"});
        cyc(e_t2(), {tag, "_t2"});
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        @(posedge clk);
        #1;
        cyc(e_off(), "reset");
        rst = 1'b0;
        cyc(e_off(), "rst_exit");

        // AND R5,R2,R4
        ir = 32'h4A920000;
        cyc(e_t0(), "and_t0");
        fetch(0, "and");
        cyc(e_t3(2, 1'b0), "and_t3");
        cyc(e_t4(4, A_AND), "and_t4");
        cyc(e_t5(5), "and_t5");

        // SUB R1,R3,R6 with three stall cycles in T1
        ir = mk_ir(5'b00100, 4'd1, 4'd3, 4'd6);
        cyc(e_t0(), "sub_t0");
        fetch(3, "sub");
        cyc(e_t3(3, 1'b0), "sub_t3");
        cyc(e_t4(6, A_SUB), "sub_t4");
        cyc(e_t5(1), "sub_t5");

        // NEGATE R7,R9: T4 drives Rb
        ir = mk_ir(5'b10001, 4'd7, 4'd9, 4'd1);
        cyc(e_t0(), "neg_t0");
        fetch(0, "neg");
        cyc(e_t3(9, 1'b0), "neg_t3");
        cyc(e_t4(9, A_NEG), "neg_t4");
        cyc(e_t5(7), "neg_t5");

        // MUL R1,R2,R3
        ir = mk_ir(5'b01111, 4'd1, 4'd2, 4'd3);
        cyc(e_t0(), "mul_t0");
        fetch(0, "mul");
`ifdef CU_MULDIV_EN
        cyc(e_t3(2, 1'b0), "mul_t3");
        cyc(e_t4(3, A_MUL), "mul_t4");
        cyc(e_t5m(), "mul_t5");
        cyc(e_t6(), "mul_t6");
`else
        cyc(e_t3(2, 1'b1), "mul_t3_illegal");
`endif

        // opcode 11111 is illegal
        ir = 32'hF8000000;
        cyc(e_t0(), "ill_t0");
        fetch(0, "ill");
        cyc(e_t3(0, 1'b1), "ill_t3");

        // OR R3,R4,R5 abandoned by reset in the middle of T4
        ir = mk_ir(5'b01010, 4'd3, 4'd4, 4'd5);
        cyc(e_t0(), "or_t0");
        fetch(0, "or");
        cyc(e_t3(4, 1'b0), "or_t3");
        exp_q.push_back(e_t4(5, A_OR));
        name_q.push_back("or_t4");
        @(negedge clk);
        #2;
        exp_q.push_back(e_off());
        name_q.push_back("rst_async");
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc(e_off(), "rst_held");
        rst = 1'b0;
        cyc(e_off(), "rst_deasserted");

        // ADD R1,R2,R3; Stop outside instruction end is ignored, at T5 it halts
        ir = mk_ir(5'b00011, 4'd1, 4'd2, 4'd3);
        stop = 1'b1;
        cyc(e_t0(), "add_t0");
        stop = 1'b0;
        fetch(0, "add");
        stop = 1'b1;
        cyc(e_t3(2, 1'b0), "add_t3");
        stop = 1'b0;
        cyc(e_t4(3, A_ADD), "add_t4");
        stop = 1'b1;
        cyc(e_t5(1), "add_t5");
        for (int i = 0; i < 10; i++) begin
            cyc(e_off(), $sformatf("halt_%0d", i));
        end
        rst = 1'b1;
        cyc(e_off(), "halt_rst");
        rst = 1'b0;
        stop = 1'b0;
        cyc(e_off(), "halt_exit");
        cyc(e_t0(), "post_halt_t0");

        @(negedge clk);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Clock  in  1  single system clock; all state changes on the rising edge.
REQ-002 Reset  in  1  asynchronous, active-high reset.
REQ-003 IR  in  32  instruction register contents; opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
REQ-004 MemStall  in  1  memory not ready; holds the fetch-read step.
REQ-005 Stop  in  1  halt request, sampled at instruction end.
REQ-006 Rin  out  16  one-hot general-register load strobes; bit n = Rn.
REQ-007 Rout  out  16  one-hot general-register bus-drive strobes; bit n = Rn.
REQ-008 PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, RYin, RZin, Zlowout, Zhighout, HIin, LOin, Read  out  1 each  datapath strobes.
REQ-009 ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT  out  1 each  one-hot ALU operation select.
REQ-010 Run  out  1  high while sequencing instructions.
REQ-011 Illegal  out  1  one-cycle pulse on an undecodable opcode.

Function
REQ-012 Moore FSM with states RST, T0, T1, T2, T3, T4, T5, T6, HALT; outputs decode from the state register and the latched IR only.
REQ-013 At most one state is active per cycle, every Rin/Rout vector is one-hot or zero, and at most one bus driver is asserted per cycle.
REQ-014 RST: all outputs 0; next state is T0.
REQ-015 T0: PCout, MARin, IncPC, RZin asserted; next state is T1.
REQ-016 T1: Zlowout, PCin, Read, MDRin asserted; while MemStall=1 the FSM stays in T1 and PCin is asserted only in the last T1 cycle; when MemStall=0 the next state is T2.
REQ-017 T2: MDRout, IRin asserted; next state is T3.
REQ-018 T3: Rout[Rb], RYin asserted; if the opcode is illegal, Illegal pulses and the next state is T0.
REQ-019 T4 (binary ops): Rout[Rc], the ALU select, and RZin asserted; for NEGATE/NOT, Rout[Rb] is driven instead of Rout[Rc].
REQ-020 T5: Zlowout and Rin[Ra] asserted; for MUL/DIV, Zlowout and LOin are asserted instead and the next state is T6.
REQ-021 T6 (MUL/DIV only): Zhighout, HIin asserted.
REQ-022 Opcodes: ADD 00011, SUB 00100, SHR 00101, SHL 00110, ROR 00111, ROL 01000, AND 01001, OR 01010, MUL 01111, DIV 10000, NEGATE 10001, NOT 10010; all other opcodes are illegal.
REQ-023 Instruction end is T5 (T6 for MUL/DIV): if Stop=1 the next state is HALT, otherwise T0.
REQ-024 HALT: all outputs 0 and Run=0; HALT is left only by Reset.
REQ-025 Latency: 6 cycles per instruction (7 for MUL/DIV) plus one cycle per stall cycle; an illegal opcode costs 4 cycles.
REQ-026 Stop asserted anywhere other than instruction end is ignored unless it is still high at instruction end.

Reset
REQ-027 Reset=1 forces state RST immediately, and all outputs, including Run and Illegal, go to 0 regardless of the clock.
REQ-028 Reset mid-instruction abandons the instruction; no Rin, PCin, HIin, or LOin strobe is produced after Reset asserts.
REQ-029 The first rising edge after Reset deasserts moves RST to T0; Run=1 from T0 onward.

Configuration
REQ-030 Macro CU_MULDIV_EN: when defined, MUL/DIV decode per REQ-020/021; when undefined, opcodes 01111 and 10000 are illegal, the MUL and DIV outputs are tied to 0, and state T6 is unreachable.

Structure
REQ-031 Package cu_pkg holds the state enum, the 5-bit opcode constants, and the IR field bit positions.
REQ-032 Sub-module cu_decode is combinational: IR to one-hot ALU select, Ra/Rb/Rc one-hot vectors, and the illegal/muldiv flags; the FSM lives in control_unit.

Verification
REQ-033 Bench shall cover: IR=0x4A920000 (and R5,R2,R4) -> T3 Rout[2]+RYin, T4 Rout[4]+AND+RZin, T5 Zlowout+Rin[5], then back to T0.
REQ-034 Bench shall cover: MemStall high for 3 cycles in T1 -> T1 held 4 cycles, PCin exactly once, T2 on the 5th cycle.
REQ-035 Bench shall cover: MUL opcode 01111 with CU_MULDIV_EN defined -> T5 LOin, T6 HIin+Zhighout; with the macro undefined -> Illegal pulse in T3, return to T0, no LOin/HIin.
REQ-036 Bench shall cover: opcode 11111 -> Illegal=1 for one cycle in T3, no Rin, then T0.
REQ-037 Bench shall cover: Reset asserted mid-T4 -> all outputs 0 before the next edge, RST, then T0 after deassert.
REQ-038 Bench shall cover: Stop=1 at T5 -> HALT, Run=0, outputs 0; held through 10 cycles until Reset.
